systolic_ctrl: RTL and testbench

SYSTOLIC_CTRL -- requirements
Module: systolic_ctrl

---
 rtl/systolic_ctrl_if.sv | 28 ++
 rtl/systolic_ctrl.sv | 76 +++++++
 tb/tb_systolic_ctrl.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_ctrl_if.sv
// systolic_ctrl_if: tile launch, operand stream, result stream and array control signals
interface systolic_ctrl_if #(
  parameter int N = 4,
  parameter int K_W = 8,
  parameter int RW = (N > 1) ? $clog2(N) : 1
);
  logic start;
  logic [K_W-1:0] k_len;
  logic src_valid;
  logic src_ready;
  logic dst_ready;
  logic feed_en;
  logic zero_fill;
  logic acc_clr;
  logic acc_en;
  logic out_valid;
  logic [RW-1:0] out_row;
  logic busy;
  logic done;
  modport master (
    output start, k_len, src_valid, dst_ready,
    input src_ready, feed_en, zero_fill, acc_clr, acc_en, out_valid, out_row, busy, done
  );
  modport slave (
    input start, k_len, src_valid, dst_ready,
    output src_ready, feed_en, zero_fill, acc_clr, acc_en, out_valid, out_row, busy, done
  );
endinterface

// File: rtl/systolic_ctrl.sv
// systolic_ctrl: sequences clear, operand feed, pipeline drain and row readout for an N x N array
module systolic_ctrl #(
  parameter int N = 4,
  parameter int K_W = 8
) (
  input logic clk,
  input logic clear,
  systolic_ctrl_if.slave bus
);
  localparam int RW = (N > 1) ? $clog2(N) : 1;
  localparam int DW = $clog2(2 * N);
  typedef enum logic [2:0] {IDLE, CLR, FEED, DRAIN, OUT} state_t;
  state_t st, nxt;
  logic [K_W-1:0] k_q, bcnt;
  logic [DW-1:0] dcnt;
  logic [RW-1:0] row;
  logic done_q;
  logic last_beat, last_drain, last_row;
  assign last_beat = bus.src_valid && bcnt == k_q - K_W'(1);
  assign last_drain = dcnt == DW'(2 * N - 3);
  assign last_row = row == RW'(N - 1);
  assign bus.out_row = row;
  assign bus.done = done_q;
  assign bus.busy = st != IDLE;
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      st <= IDLE;
      k_q <= '0;
      bcnt <= '0;
      dcnt <= '0;
      row <= '0;
      done_q <= 1'b0;
    end else begin
      st <= nxt;
      done_q <= (st == IDLE && bus.start && bus.k_len == '0) ||
                (st == OUT && bus.dst_ready && last_row);
      if (st == IDLE && bus.start) k_q <= bus.k_len;
      bcnt <= (st == FEED) ? bcnt + K_W'(bus.src_valid) : '0;
      dcnt <= (st == DRAIN) ? dcnt + DW'(1) : '0;
      row <= (st != OUT || (bus.dst_ready && last_row)) ? '0 : row + RW'(bus.dst_ready);
    end
  end
  always_comb begin
    nxt = st;
    bus.src_ready = 1'b0;
    bus.feed_en = 1'b0;
    bus.acc_en = 1'b0;
    bus.zero_fill = 1'b0;
    bus.acc_clr = 1'b0;
    bus.out_valid = 1'b0;
    case (st)
      IDLE: nxt = (bus.start && bus.k_len != '0) ? CLR : IDLE;
      CLR: begin
        bus.acc_clr = 1'b1;
        nxt = FEED;
      end
      FEED: begin
        bus.src_ready = 1'b1;
        bus.feed_en = bus.src_valid;
        bus.acc_en = bus.src_valid;
        nxt = last_beat ? ((N == 1) ? OUT : DRAIN) : FEED;
      end
      DRAIN: begin
        bus.feed_en = 1'b1;
        bus.acc_en = 1'b1;
        bus.zero_fill = 1'b1;
        nxt = last_drain ? OUT : DRAIN;
      end
      OUT: begin
        bus.out_valid = 1'b1;
        nxt = (bus.dst_ready && last_row) ? IDLE : OUT;
      end
      default: nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_systolic_ctrl.sv
// tb_systolic_ctrl: directed cycle-by-cycle schedule checks for systolic_ctrl with N=4
module tb_systolic_ctrl;
  logic clk = 1'b0;
  logic clear = 1'b0;
  int checks = 0;
  int failures = 0;
  systolic_ctrl_if #(.N(4), .K_W(8)) bus();
  systolic_ctrl #(.N(4), .K_W(8)) dut (.clk(clk), .clear(clear), .bus(bus));
  always #5 clk = ~clk;
  // {busy, acc_clr, src_ready, feed_en, acc_en, zero_fill, out_valid, done}
  localparam logic [7:0] V_IDLE  = 8'b0000_0000;
  localparam logic [7:0] V_CLR   = 8'b1100_0000;
  localparam logic [7:0] V_FEED  = 8'b1011_1000;
  localparam logic [7:0] V_STALL = 8'b1010_0000;
  localparam logic [7:0] V_DRAIN = 8'b1001_1100;
  localparam logic [7:0] V_OUT   = 8'b1000_0010;
  localparam logic [7:0] V_DONE  = 8'b0000_0001;
  function automatic logic [7:0] obs();
    return {bus.busy, bus.acc_clr, bus.src_ready, bus.feed_en, bus.acc_en,
            bus.zero_fill, bus.out_valid, bus.done};
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    bus.start = 0; bus.k_len = 0; bus.src_valid = 0; bus.dst_ready = 0;
    #1 clear = 1;
    #2;
    checks++;
    if (obs() !== V_IDLE || bus.out_row !== 2'd0) begin
      failures++; $display("FAIL reset_async got=%b row=%0d exp=%b row=0", obs(), bus.out_row, V_IDLE);
    end
    step(); step();
    checks++;
    if (obs() !== V_IDLE) begin
      failures++; $display("FAIL reset_held got=%b exp=%b", obs(), V_IDLE);
    end
    clear = 0;
  endtask
  task automatic test_basic();
    logic [7:0] e;
    bus.start = 1; bus.k_len = 3; bus.src_valid = 1; bus.dst_ready = 1;
    #1;
    checks++;
    if (obs() !== V_IDLE) begin
      failures++; $display("FAIL basic c=0 got=%b exp=%b", obs(), V_IDLE);
    end
    for (int c = 1; c <= 16; c++) begin
      step();
      bus.start = 0;
      #1;
      e = c == 1 ? V_CLR : c <= 4 ? V_FEED : c <= 10 ? V_DRAIN : c <= 14 ? V_OUT : c == 15 ? V_DONE : V_IDLE;
      checks++;
      if (obs() !== e) begin
        failures++; $display("FAIL basic c=%0d got=%b exp=%b", c, obs(), e);
      end
      if (c >= 11 && c <= 14) begin
        checks++;
        if (bus.out_row !== 2'(c - 11)) begin
          failures++; $display("FAIL basic_row c=%0d got=%0d exp=%0d", c, bus.out_row, c - 11);
        end
      end
    end
  endtask
  task automatic test_stall();
    logic [7:0] e;
    int beats = 0;
    bus.start = 1; bus.k_len = 3; bus.src_valid = 1; bus.dst_ready = 1;
    step();
    for (int c = 1; c <= 18; c++) begin
      bus.start = 0;
      bus.src_valid = !(c == 3 || c == 4);
      #1;
      e = c == 1 ? V_CLR : (c == 3 || c == 4) ? V_STALL : c <= 6 ? V_FEED : c <= 12 ? V_DRAIN :
          c <= 16 ? V_OUT : c == 17 ? V_DONE : V_IDLE;
      if (bus.src_ready && bus.src_valid) beats++;
      checks++;
      if (obs() !== e) begin
        failures++; $display("FAIL stall c=%0d got=%b exp=%b", c, obs(), e);
      end
      step();
    end
    bus.src_valid = 1;
    checks++;
    if (beats !== 3) begin
      failures++; $display("FAIL stall_beats got=%0d exp=3", beats);
    end
  endtask
  task automatic test_backpressure();
    logic [7:0] e;
    int r;
    bus.start = 1; bus.k_len = 2; bus.src_valid = 1; bus.dst_ready = 1;
    step();
    for (int c = 1; c <= 18; c++) begin
      bus.start = 0;
      bus.dst_ready = !(c >= 11 && c <= 13);
      #1;
      e = c == 1 ? V_CLR : c <= 3 ? V_FEED : c <= 9 ? V_DRAIN : c <= 16 ? V_OUT : c == 17 ? V_DONE : V_IDLE;
      r = c <= 10 ? 0 : c <= 14 ? 1 : c - 13;
      checks++;
      if (obs() !== e) begin
        failures++; $display("FAIL bp c=%0d got=%b exp=%b", c, obs(), e);
      end
      if (c >= 10 && c <= 16) begin
        checks++;
        if (bus.out_row !== 2'(r)) begin
          failures++; $display("FAIL bp_row c=%0d got=%0d exp=%0d", c, bus.out_row, r);
        end
      end
      step();
    end
    bus.dst_ready = 1;
  endtask
  task automatic test_zero_k();
    logic [7:0] e;
    bus.start = 1; bus.k_len = 0;
    #1;
    checks++;
    if (obs() !== V_IDLE) begin
      failures++; $display("FAIL zero_k c=0 got=%b exp=%b", obs(), V_IDLE);
    end
    for (int c = 1; c <= 3; c++) begin
      step();
      bus.start = 0;
      #1;
      e = c == 1 ? V_DONE : V_IDLE;
      checks++;
      if (obs() !== e) begin
        failures++; $display("FAIL zero_k c=%0d got=%b exp=%b", c, obs(), e);
      end
    end
  endtask
  task automatic test_clear_drain();
    logic [7:0] e;
    bus.start = 1; bus.k_len = 1; bus.src_valid = 1; bus.dst_ready = 1;
    step();
    for (int c = 1; c <= 5; c++) begin
      bus.start = 0;
      #1;
      e = c == 1 ? V_CLR : c == 2 ? V_FEED : V_DRAIN;
      checks++;
      if (obs() !== e) begin
        failures++; $display("FAIL clr_pre c=%0d got=%b exp=%b", c, obs(), e);
      end
      if (c < 5) step();
    end
    clear = 1;
    #1;
    checks++;
    if (obs() !== V_IDLE || bus.out_row !== 2'd0) begin
      failures++; $display("FAIL clr_async got=%b row=%0d exp=%b row=0", obs(), bus.out_row, V_IDLE);
    end
    step(); step();
    clear = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      checks++;
      if (obs() !== V_IDLE) begin
        failures++; $display("FAIL clr_nodone c=%0d got=%b exp=%b", c, obs(), V_IDLE);
      end
    end
    bus.start = 1; bus.k_len = 2;
    step();
    for (int c = 1; c <= 15; c++) begin
      bus.start = 0;
      #1;
      e = c == 1 ? V_CLR : c <= 3 ? V_FEED : c <= 9 ? V_DRAIN : c <= 13 ? V_OUT : c == 14 ? V_DONE : V_IDLE;
      checks++;
      if (obs() !== e) begin
        failures++; $display("FAIL clr_rerun c=%0d got=%b exp=%b", c, obs(), e);
      end
      step();
    end
  endtask
  task automatic test_start_held();
    logic [7:0] e;
    bus.start = 1; bus.k_len = 1; bus.src_valid = 1; bus.dst_ready = 1;
    step();
    for (int c = 1; c <= 31; c++) begin
      bus.start = c <= 13;
      if (c >= 2) bus.k_len = 5;
      #1;
      e = c == 1 ? V_CLR : c == 2 ? V_FEED : c <= 8 ? V_DRAIN : c <= 12 ? V_OUT : c == 13 ? V_DONE :
          c == 14 ? V_CLR : c <= 19 ? V_FEED : c <= 25 ? V_DRAIN : c <= 29 ? V_OUT : c == 30 ? V_DONE : V_IDLE;
      checks++;
      if (obs() !== e) begin
        failures++; $display("FAIL held c=%0d got=%b exp=%b", c, obs(), e);
      end
      step();
    end
    bus.start = 0;
  endtask
  task automatic test_max_k();
    logic [7:0] e;
    bus.start = 1; bus.k_len = 8'd255; bus.src_valid = 1; bus.dst_ready = 1;
    step();
    for (int c = 1; c <= 268; c++) begin
      bus.start = 0;
      #1;
      e = c == 1 ? V_CLR : c <= 256 ? V_FEED : c <= 262 ? V_DRAIN : c <= 266 ? V_OUT : c == 267 ? V_DONE : V_IDLE;
      checks++;
      if (obs() !== e) begin
        failures++; $display("FAIL max_k c=%0d got=%b exp=%b", c, obs(), e);
      end
      step();
    end
  endtask
  initial begin
    test_reset();
    step();
    test_basic();
    step();
    test_stall();
    test_backpressure();
    test_zero_k();
    step();
    test_clear_drain();
    test_start_held();
    test_max_k();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
